// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states
// and the alignment rule used at op acceptance.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational lane logic: extracts and extends load lanes from a memory
// word, and merges store data into a memory word for read-modify-write.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    output logic [31:0] ld_ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ld_ext = rdata;
        case (size)
            SZ_BYTE: ld_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: ld_ext = rdata;
        endcase
    end

    // Only the addressed lanes take store data; the rest keep the read word.
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[31:16] = wdata[15:0];
                else        merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/RD/WR FSM driving a single-port word memory.
// Optional macro MAU_WB_FWD_EN selects WB-stage forwarded store data.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_signed,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic        fwd_sel,
    input  logic [31:0] fwd_data,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout,
    output logic [1:0]  state_dbg
);

    // Handshake: the pipeline presents an op while in IDLE and keeps every op
    // input stable for as long as stall=1; the op is complete on the first
    // cycle it sees stall=0, and op inputs are ignored outside IDLE.

    logic [1:0]  state;
    logic        cap_store;
    logic        cap_signed;
    logic [1:0]  cap_size;
    logic [1:0]  cap_off;
    logic [31:0] cap_wdata;
    logic        op_go;
    logic        op_ok;
    logic [31:0] store_data;
    logic [31:0] lane_ext;
    logic [31:0] lane_merged;

`ifdef MAU_WB_FWD_EN
    assign store_data = fwd_sel ? fwd_data : op_wdata;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_sel, fwd_data};
    assign store_data = op_wdata;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^op_addr[31:12];

    assign op_go     = (state == IDLE) && op_valid && (op_load || op_store);
    assign op_ok     = op_go && is_aligned(op_size, op_addr[1:0]);
    assign stall     = op_ok || ((state == RD) && cap_store);
    assign state_dbg = state;

    mau_lane u_lane (
        .rdata    (mem_dout),
        .wdata    (cap_wdata),
        .size     (cap_size),
        .off      (cap_off),
        .sign_ext (cap_signed),
        .ld_ext   (lane_ext),
        .merged   (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            ld_valid   <= 1'b0;
            ld_data    <= '0;
            misalign   <= 1'b0;
            cap_store  <= 1'b0;
            cap_signed <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_off    <= 2'b00;
            cap_wdata  <= '0;
        end else begin
            ld_valid <= 1'b0;
            misalign <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_go && !op_ok) begin
                        misalign <= 1'b1;
                    end else if (op_ok) begin
                        mem_addr   <= op_addr[11:2];
                        cap_store  <= op_store;
                        cap_signed <= op_signed;
                        cap_size   <= op_size;
                        cap_off    <= op_addr[1:0];
                        cap_wdata  <= store_data;
                        // Full-word stores need no read; sub-word stores go through RD.
                        if (op_store && op_size[1]) begin
                            state   <= WR;
                            mem_we  <= 1'b1;
                            mem_din <= store_data;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (cap_store) begin
                        mem_din <= lane_merged;
                        mem_we  <= 1'b1;
                        state   <= WR;
                    end else begin
                        ld_valid <= 1'b1;
                        ld_data  <= lane_ext;
                        state    <= IDLE;
                    end
                end
                WR:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports (clock and reset first): clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low.
REQ-002 SHALL have pipeline-side inputs: op_valid in 1, MEM-stage op present; op_load in 1; op_store in 1; op_size in 2 (00 byte, 01 half, 10 word, 11 treated as word); op_signed in 1, load sign-extend; op_addr in 32, byte address; op_wdata in 32, store data; fwd_sel in 1, store-data forward select; fwd_data in 32, WB-stage result.
REQ-003 SHALL have pipeline-side outputs: stall out 1, hold pipeline; ld_valid out 1, load result valid; ld_data out 32, extended load result; misalign out 1, alignment-fault pulse.
REQ-004 SHALL have memory-side ports: mem_addr out 10, word address; mem_din out 32, write word; mem_we out 1, write enable; mem_dout in 32, combinational read word.

Function
REQ-005 SHALL implement FSM states IDLE, RD, WR; all memory-side outputs and ld_valid, ld_data and misalign registered.
REQ-006 SHALL accept an op in IDLE when op_valid=1 and op_load|op_store=1; op_store=1 takes priority when both are set; op_valid with neither flag is a no-op with no stall.
REQ-007 SHALL define alignment as: half needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
REQ-008 SHALL handle a misaligned op as follows: no state change, mem_we=0, misalign=1 for exactly the next cycle, stall=0.
REQ-009 SHALL drive mem_addr = op_addr[11:2] captured at acceptance and held through the op.
REQ-010 SHALL execute an aligned word store as IDLE->WR->IDLE; in WR, mem_we=1 and mem_din equals the captured store data.
REQ-011 SHALL execute an aligned byte/half store as IDLE->RD->WR->IDLE: in RD, capture mem_dout; in WR, write that word with only the addressed lanes replaced.
REQ-012 SHALL execute an aligned load as IDLE->RD->IDLE: in RD, extract the addressed lanes from mem_dout; in the following cycle, ld_valid=1 for exactly one cycle with ld_data valid.
REQ-013 SHALL use little-endian lane order: byte n = bits [8n+7:8n]; half at addr[1]=1 = bits [31:16].
REQ-014 SHALL extend loads as follows: op_signed=1 sign-extends, op_signed=0 zero-extends; a word load passes through unchanged.
REQ-015 SHALL set stall=1 in the acceptance cycle and in every busy cycle except the final one (RD for loads, WR for stores); stall=0 in IDLE with no accepted op.
REQ-016 SHALL ignore op inputs while not in IDLE; the pipeline holds them stable while stall=1.
REQ-017 SHALL hold ld_data at its last value when ld_valid=0.

Reset
REQ-018 SHALL, on rst_n=0, asynchronously force: state IDLE, mem_we 0, mem_addr 0, mem_din 0, ld_valid 0, ld_data 0, misalign 0; stall then follows REQ-015.
REQ-019 SHALL abort an in-flight op when reset asserts mid-operation: no write issues, including from WR, and no ld_valid.

Configuration
REQ-020 SHALL support macro MAU_WB_FWD_EN: when defined, store data captured at acceptance = fwd_sel ? fwd_data : op_wdata; when undefined, fwd_sel and fwd_data are ignored and store data = op_wdata.

Structure
REQ-021 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings in shared package mau_pkg.
REQ-022 SHALL implement lane extract, extend and merge in combinational sub-module mau_lane, instantiated once.

Verification
REQ-023 SHALL cover word store/load: store 0xDEADBEEF @0x010, then load word @0x010 -> mem[4] written in WR, ld_data=0xDEADBEEF, ld_valid one cycle.
REQ-024 SHALL cover byte store RMW: mem[4]=0x11223344, store byte 0xAB @0x012 -> mem[4]=0x11AB3344, stall high 2 cycles.
REQ-025 SHALL cover load extension: mem[4]=0x11AB3344, load signed byte @0x012 -> 0xFFFFFFAB; unsigned -> 0x000000AB; signed half @0x012 -> 0x000011AB.
REQ-026 SHALL cover misalignment: store word @0x013 -> misalign=1 for one cycle, mem_we never high, stall 0.
REQ-027 SHALL cover reset abort: rst_n low during WR of a half store -> mem_we drops immediately, memory unchanged, FSM in IDLE.
REQ-028 SHALL cover forwarding with MAU_WB_FWD_EN defined: fwd_sel=1, fwd_data=0x0000CAFE, op_wdata=0 -> stored word 0x0000CAFE; with the macro undefined -> stored word 0.
